// File: rtl/mac3_sequencer.sv
// Beat sequencer for a 3-tap MAC: issues beats, drains the MAC pipeline and hands out results.
// Optional performance counters are compiled in with MAC3_SEQ_PERF_CNT_EN.
module mac3_sequencer #(
   parameter int unsigned PIPE_DEPTH = 4,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                 clk,
   input  logic                 arst_n_in,
   input  logic                 start,
   input  logic [CNT_WIDTH-1:0] beats_per_out,
   input  logic [31:0]          num_outputs,
   input  logic                 src_valid,
   output logic                 src_ready,
   output logic                 mac_input_valid,
   output logic                 mac_accumulate_internal,
   output logic                 mac_zero_operands,
   output logic [31:0]          mac_ch_out,
   output logic                 mac_out_written_to_mem,
   output logic                 res_valid,
   input  logic                 res_ready,
   output logic [31:0]          res_ch,
   output logic                 busy,
   output logic                 done,
   output logic [31:0]          perf_beats,
   output logic [31:0]          perf_stalls
);

   localparam int unsigned IDX_W = 32;
   localparam int unsigned DRN_W = $clog2(PIPE_DEPTH) + 1;
   localparam logic [DRN_W-1:0] DRAIN_BEATS = DRN_W'(PIPE_DEPTH - 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] RUN   = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;

   logic [1:0]           state_q;
   logic [1:0]           state_d;
   logic                 done_q;
   logic                 done_d;
   logic [CNT_WIDTH-1:0] bpo_q;
   logic [CNT_WIDTH-1:0] beat_q;
   logic [IDX_W-1:0]     nout_q;
   logic [IDX_W-1:0]     out_idx_q;
   logic [DRN_W-1:0]     drn_q;
   logic                 taken_q;
   logic                 shadow_last_q [PIPE_DEPTH];
   logic [IDX_W-1:0]     shadow_ch_q   [PIPE_DEPTH];

   logic in_run;
   logic in_drain;
   logic blocked;
   logic issue;
   logic beat_last;
   logic job_last;
   logic drain_all;
   logic fin_accept;
   logic start_ok;
   logic start_zero;

   // Issue qualification: a presented, unaccepted result freezes the MAC pipeline.
   assign in_run     = (state_q == RUN);
   assign in_drain   = (state_q == DRAIN);
   assign res_valid  = shadow_last_q[PIPE_DEPTH-1] && !taken_q;
   assign res_ch     = shadow_ch_q[PIPE_DEPTH-1];
   assign blocked    = res_valid && !res_ready;
   assign drain_all  = (drn_q == DRAIN_BEATS);
   assign issue      = (in_run ? src_valid : (in_drain && !drain_all)) && !blocked;
   assign beat_last  = (beat_q == bpo_q - CNT_WIDTH'(1));
   assign job_last   = beat_last && (out_idx_q == nout_q - IDX_W'(1));
   assign fin_accept = in_drain && drain_all && res_valid && res_ready;
   assign start_ok   = (state_q == IDLE) && start;
   assign start_zero = (num_outputs == '0) || (beats_per_out == '0);

   assign mac_input_valid         = issue;
   assign src_ready               = in_run && issue;
   assign mac_accumulate_internal = in_drain || (in_run && (beat_q != '0));
   assign mac_zero_operands       = in_drain;
   assign mac_ch_out              = in_run ? out_idx_q : '0;
   assign mac_out_written_to_mem  = in_run && beat_last;
   assign busy                    = in_run || in_drain;
   assign done                    = done_q;

   always_ff @(posedge clk) begin
      if (!arst_n_in) begin
         state_q <= IDLE;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (start_zero) begin
                  done_d = 1'b1;
               end else begin
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            if (issue && job_last) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (fin_accept) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Job parameters and beat / output / drain counters.
   always_ff @(posedge clk) begin
      if (!arst_n_in) begin
         bpo_q     <= '0;
         nout_q    <= '0;
         beat_q    <= '0;
         out_idx_q <= '0;
         drn_q     <= '0;
      end else if (start_ok) begin
         bpo_q     <= beats_per_out;
         nout_q    <= num_outputs;
         beat_q    <= '0;
         out_idx_q <= '0;
         drn_q     <= '0;
      end else if (issue) begin
         if (in_run) begin
            if (beat_last) begin
               beat_q    <= '0;
               out_idx_q <= out_idx_q + IDX_W'(1);
            end else begin
               beat_q <= beat_q + CNT_WIDTH'(1);
            end
         end else begin
            drn_q <= drn_q + DRN_W'(1);
         end
      end
   end

   // Shadow of the MAC pipeline; taken suppresses re-delivery of a head entry that cannot move yet.
   always_ff @(posedge clk) begin
      if (!arst_n_in || start_ok) begin
         for (int i = 0; i < PIPE_DEPTH; i++) begin
            shadow_last_q[i] <= 1'b0;
            shadow_ch_q[i]   <= '0;
         end
         taken_q <= 1'b0;
      end else if (issue) begin
         shadow_last_q[0] <= in_run && beat_last;
         shadow_ch_q[0]   <= in_run ? out_idx_q : '0;
         for (int i = 1; i < PIPE_DEPTH; i++) begin
            shadow_last_q[i] <= shadow_last_q[i-1];
            shadow_ch_q[i]   <= shadow_ch_q[i-1];
         end
         taken_q <= 1'b0;
      end else if (res_valid && res_ready) begin
         taken_q <= 1'b1;
      end
   end

`ifdef MAC3_SEQ_PERF_CNT_EN
   logic [31:0] perf_beats_q;
   logic [31:0] perf_stalls_q;

   // The completion cycle has nothing left to issue, so it is not counted as a stall.
   always_ff @(posedge clk) begin
      if (!arst_n_in || start_ok) begin
         perf_beats_q  <= '0;
         perf_stalls_q <= '0;
      end else begin
         if (issue) begin
            perf_beats_q <= perf_beats_q + 32'd1;
         end
         if (busy && !issue && !fin_accept) begin
            perf_stalls_q <= perf_stalls_q + 32'd1;
         end
      end
   end

   assign perf_beats  = perf_beats_q;
   assign perf_stalls = perf_stalls_q;
`else
   assign perf_beats  = '0;
   assign perf_stalls = '0;
`endif

endmodule

// File: tb/tb_mac3_sequencer.sv
// Directed self-checking bench for mac3_sequencer (PIPE_DEPTH=4); perf checks follow MAC3_SEQ_PERF_CNT_EN.
module tb_mac3_sequencer;

   localparam int unsigned PIPE_DEPTH = 4;
   localparam int unsigned CNT_WIDTH  = 16;

   logic                 clk = 1'b0;
   logic                 arst_n_in;
   logic                 start;
   logic [CNT_WIDTH-1:0] beats_per_out;
   logic [31:0]          num_outputs;
   logic                 src_valid;
   logic                 src_ready;
   logic                 mac_input_valid;
   logic                 mac_accumulate_internal;
   logic                 mac_zero_operands;
   logic [31:0]          mac_ch_out;
   logic                 mac_out_written_to_mem;
   logic                 res_valid;
   logic                 res_ready;
   logic [31:0]          res_ch;
   logic                 busy;
   logic                 done;
   logic [31:0]          perf_beats;
   logic [31:0]          perf_stalls;

   int n_checks = 0;
   int n_pass   = 0;

   int j_issue;
   int j_run;
   int j_drain;
   int j_res;
   int j_done;
   int res_log [16];

   mac3_sequencer #(.PIPE_DEPTH(PIPE_DEPTH), .CNT_WIDTH(CNT_WIDTH)) dut (
      .clk                     (clk),
      .arst_n_in               (arst_n_in),
      .start                   (start),
      .beats_per_out           (beats_per_out),
      .num_outputs             (num_outputs),
      .src_valid               (src_valid),
      .src_ready               (src_ready),
      .mac_input_valid         (mac_input_valid),
      .mac_accumulate_internal (mac_accumulate_internal),
      .mac_zero_operands       (mac_zero_operands),
      .mac_ch_out              (mac_ch_out),
      .mac_out_written_to_mem  (mac_out_written_to_mem),
      .res_valid               (res_valid),
      .res_ready               (res_ready),
      .res_ch                  (res_ch),
      .busy                    (busy),
      .done                    (done),
      .perf_beats              (perf_beats),
      .perf_stalls             (perf_stalls)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // src_mode 0: always valid, 1: valid on even cycles, 2: invalid on cycles 1,3,5,7.
   task automatic run_job(input int bpo, input int nout, input int src_mode, input int stall_len);
      int beat;
      int oidx;
      int stall_left;
      bit stall_used;
      bit fin;
      logic [31:0] held_ch;
      beat = 0; oidx = 0; stall_left = 0; stall_used = 1'b0; fin = 1'b0; held_ch = '0;
      j_issue = 0; j_run = 0; j_drain = 0; j_res = 0; j_done = 0;
      beats_per_out = CNT_WIDTH'(bpo);
      num_outputs   = 32'(nout);
      start         = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
         case (src_mode)
            0:       src_valid = 1'b1;
            1:       src_valid = (cyc % 2 == 0);
            default: src_valid = !(cyc inside {1, 3, 5, 7});
         endcase
         if (res_valid && stall_len > 0 && !stall_used) begin
            stall_used = 1'b1;
            stall_left = stall_len;
            held_ch    = res_ch;
         end
         res_ready = (stall_left == 0);
         #1;
         if (stall_left > 0) begin
            check("stall_issue", 32'(mac_input_valid), 32'd0);
            check("stall_src_ready", 32'(src_ready), 32'd0);
            check("stall_res_valid", 32'(res_valid), 32'd1);
            check("stall_res_ch", res_ch, held_ch);
            stall_left--;
         end
         if (src_ready) begin
            check("run_acc", 32'(mac_accumulate_internal), 32'(beat != 0));
            check("run_last", 32'(mac_out_written_to_mem), 32'(beat == bpo - 1));
            check("run_ch", mac_ch_out, 32'(oidx));
            if (beat == bpo - 1) begin
               beat = 0;
               oidx++;
            end else begin
               beat++;
            end
            j_run++;
         end
         if (mac_input_valid && mac_zero_operands) begin
            check("drain_acc", 32'(mac_accumulate_internal), 32'd1);
            check("drain_last", 32'(mac_out_written_to_mem), 32'd0);
            j_drain++;
         end
         if (mac_input_valid) j_issue++;
         if (res_valid && res_ready) begin
            if (j_res < 16) res_log[j_res] = int'(res_ch);
            j_res++;
         end
         if (done) begin
            j_done++;
            fin = 1'b1;
         end
         @(posedge clk); #1;
      end
      if (!fin) check("job_timeout", 32'd0, 32'd1);
      for (int k = 0; k < 3; k++) begin
         #1;
         if (done) j_done++;
         @(posedge clk); #1;
      end
      src_valid = 1'b0;
      res_ready = 1'b0;
   endtask

   task automatic check_job(input string tag, input int issues, input int runs, input int nout);
      check({tag, "_issues"}, 32'(j_issue), 32'(issues));
      check({tag, "_run_beats"}, 32'(j_run), 32'(runs));
      check({tag, "_drain_beats"}, 32'(j_drain), 32'(PIPE_DEPTH - 1));
      check({tag, "_results"}, 32'(j_res), 32'(nout));
      for (int i = 0; i < nout && i < 16; i++) check({tag, "_res_ch"}, 32'(res_log[i]), 32'(i));
      check({tag, "_done_count"}, 32'(j_done), 32'd1);
      check({tag, "_busy_after"}, 32'(busy), 32'd0);
   endtask

   initial begin
      arst_n_in = 1'b0; start = 1'b0; beats_per_out = '0; num_outputs = '0;
      src_valid = 1'b0; res_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      arst_n_in = 1'b1;
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_res_valid", 32'(res_valid), 32'd0);
      check("rst_issue", 32'(mac_input_valid), 32'd0);
      check("rst_res_ch", res_ch, 32'd0);
      check("rst_perf_beats", perf_beats, 32'd0);

      // Basic job: 2 beats per output, 3 outputs.
      run_job(2, 3, 0, 0);
      check_job("basic", 9, 6, 3);
`ifdef MAC3_SEQ_PERF_CNT_EN
      check("basic_perf_beats", perf_beats, 32'd9);
      check("basic_perf_stalls", perf_stalls, 32'd0);
`else
      check("basic_perf_beats", perf_beats, 32'd0);
      check("basic_perf_stalls", perf_stalls, 32'd0);
`endif

      // Result back-pressure for 5 cycles.
      run_job(2, 3, 0, 5);
      check_job("bp", 9, 6, 3);

      // Toggling source valid.
      run_job(2, 3, 1, 0);
      check_job("toggle", 9, 6, 3);

      // Single-beat outputs.
      run_job(1, 4, 0, 0);
      check_job("bpo1", 7, 4, 4);

      // Four source stall cycles.
      run_job(2, 3, 2, 0);
      check_job("perf", 9, 6, 3);
`ifdef MAC3_SEQ_PERF_CNT_EN
      check("perf_beats", perf_beats, 32'd9);
      check("perf_stalls", perf_stalls, 32'd4);
`else
      check("perf_beats", perf_beats, 32'd0);
      check("perf_stalls", perf_stalls, 32'd0);
`endif

      // Zero-length job.
      beats_per_out = CNT_WIDTH'(2); num_outputs = 32'd0; src_valid = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("zero_done", 32'(done), 32'd1);
      check("zero_busy", 32'(busy), 32'd0);
      check("zero_issue", 32'(mac_input_valid), 32'd0);
      @(posedge clk); #1;
      check("zero_done_pulse", 32'(done), 32'd0);
      check("zero_busy_after", 32'(busy), 32'd0);

      // Start while busy is ignored; then reset in DRAIN.
      beats_per_out = CNT_WIDTH'(2); num_outputs = 32'd3; src_valid = 1'b1; res_ready = 1'b1;
      start = 1'b1;
      @(posedge clk); #1;
      num_outputs = 32'd0;
      @(posedge clk); #1;
      start = 1'b0;
      check("busy_start_done", 32'(done), 32'd0);
      check("busy_start_busy", 32'(busy), 32'd1);
      for (int cyc = 0; cyc < 50 && !mac_zero_operands; cyc++) begin
         @(posedge clk); #1;
      end
      check("reached_drain", 32'(mac_zero_operands), 32'd1);
      arst_n_in = 1'b0;
      @(posedge clk); #1;
      arst_n_in = 1'b1;
      #1;
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_issue", 32'(mac_input_valid), 32'd0);
      check("mid_rst_src_ready", 32'(src_ready), 32'd0);
      check("mid_rst_zero_ops", 32'(mac_zero_operands), 32'd0);
      check("mid_rst_acc", 32'(mac_accumulate_internal), 32'd0);
      check("mid_rst_res_valid", 32'(res_valid), 32'd0);
      check("mid_rst_res_ch", res_ch, 32'd0);
      check("mid_rst_done", 32'(done), 32'd0);
      check("mid_rst_perf", perf_beats, 32'd0);
      src_valid = 1'b0; res_ready = 1'b0;
      @(posedge clk); #1;

      run_job(2, 3, 0, 0);
      check_job("after_rst", 9, 6, 3);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
